// File: rtl/wb_regfile_pkg.sv
// Shared Y86-64 constants and W-stage payload type for the write-back slice.
// Build option: define RF_BYPASS_EN for write-through register reads.
package wb_regfile_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned REG_AW  = 4;
    localparam int unsigned NREGS   = 15;
    localparam int unsigned STAT_W  = 4;
    localparam int unsigned ICODE_W = 4;

    // Status codes
    localparam logic [STAT_W-1:0] SBUB = 4'h0;
    localparam logic [STAT_W-1:0] SAOK = 4'h1;
    localparam logic [STAT_W-1:0] SHLT = 4'h2;
    localparam logic [STAT_W-1:0] SADR = 4'h3;
    localparam logic [STAT_W-1:0] SINS = 4'h4;

    localparam logic [ICODE_W-1:0] INOP = 4'h1;

    // Register indices
    localparam logic [REG_AW-1:0] RRAX  = 4'h0;
    localparam logic [REG_AW-1:0] RRSP  = 4'h4;
    localparam logic [REG_AW-1:0] RNONE = 4'hF;

    typedef struct packed {
        logic [STAT_W-1:0]  stat;
        logic [ICODE_W-1:0] icode;
        logic [XLEN-1:0]    val_e;
        logic [XLEN-1:0]    val_m;
        logic [REG_AW-1:0]  dst_e;
        logic [REG_AW-1:0]  dst_m;
    } w_reg_t;

    localparam w_reg_t W_BUBBLE = '{
        stat:  SBUB,
        icode: INOP,
        val_e: '0,
        val_m: '0,
        dst_e: RNONE,
        dst_m: RNONE
    };

    // Any status other than a normal instruction or a bubble stops the machine.
    function automatic logic stat_faults(input logic [STAT_W-1:0] s);
        return (s != SAOK) && (s != SBUB);
    endfunction

endpackage

// File: rtl/wb_regfile_rf_core.sv
// 15x64 program register file: two write ports (valM wins), two async reads.
// RF_BYPASS_EN makes reads return the value being committed this cycle.
module rf_core
    import wb_regfile_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] dst_e_i,
    input  logic [XLEN-1:0]   val_e_i,
    input  logic [REG_AW-1:0] dst_m_i,
    input  logic [XLEN-1:0]   val_m_i,
    input  logic [REG_AW-1:0] src_a_i,
    input  logic [REG_AW-1:0] src_b_i,
    output logic [XLEN-1:0]   rval_a_o,
    output logic [XLEN-1:0]   rval_b_o
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Port M is applied last so it overrides port E on a shared destination.
    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we_i && (dst_e_i != RNONE)) begin
            regs_d[dst_e_i] = val_e_i;
        end
        if (we_i && (dst_m_i != RNONE)) begin
            regs_d[dst_m_i] = val_m_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        rval_a_o = '0;
        if (src_a_i != RNONE) begin
            rval_a_o = regs_q[src_a_i];
        end
`ifdef RF_BYPASS_EN
        if (we_i && (src_a_i != RNONE)) begin
            if (src_a_i == dst_m_i) begin
                rval_a_o = val_m_i;
            end else if (src_a_i == dst_e_i) begin
                rval_a_o = val_e_i;
            end
        end
`endif
    end

    always_comb begin
        rval_b_o = '0;
        if (src_b_i != RNONE) begin
            rval_b_o = regs_q[src_b_i];
        end
`ifdef RF_BYPASS_EN
        if (we_i && (src_b_i != RNONE)) begin
            if (src_b_i == dst_m_i) begin
                rval_b_o = val_m_i;
            end else if (src_b_i == dst_e_i) begin
                rval_b_o = val_e_i;
            end
        end
`endif
    end

endmodule

// File: rtl/wb_regfile.sv
// Y86-64 write-back stage: W pipeline register, commit, sticky halt, retire count.
// Build option: RF_BYPASS_EN selects write-through reads in rf_core.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        W_stall_i,
    input  logic        W_bubble_i,
    input  logic [3:0]  M_stat_i,
    input  logic [3:0]  M_icode_i,
    input  logic [63:0] M_valE_i,
    input  logic [63:0] m_valM_i,
    input  logic [3:0]  M_dstE_i,
    input  logic [3:0]  M_dstM_i,
    input  logic [3:0]  d_srcA_i,
    input  logic [3:0]  d_srcB_i,
    output logic [63:0] d_rvalA_o,
    output logic [63:0] d_rvalB_o,
    output logic [3:0]  W_stat_o,
    output logic [3:0]  W_icode_o,
    output logic [63:0] W_valE_o,
    output logic [63:0] W_valM_o,
    output logic [3:0]  W_dstE_o,
    output logic [3:0]  W_dstM_o,
    output logic        halted_o,
    output logic [63:0] retire_cnt_o
);

    w_reg_t          w_q, w_d;
    logic            halted_q, halted_d;
    logic [XLEN-1:0] retire_cnt_q, retire_cnt_d;
    logic            we_c;

    // Bubble beats stall; stall holds; otherwise take M.
    always_comb begin
        w_d = w_q;
        if (W_bubble_i) begin
            w_d = W_BUBBLE;
        end else if (!W_stall_i) begin
            w_d.stat  = M_stat_i;
            w_d.icode = M_icode_i;
            w_d.val_e = M_valE_i;
            w_d.val_m = m_valM_i;
            w_d.dst_e = M_dstE_i;
            w_d.dst_m = M_dstM_i;
        end
    end

    // A faulting status never commits, so the halt edge itself is write-free.
    always_comb begin
        we_c         = (w_q.stat == SAOK) && !halted_q;
        halted_d     = halted_q | stat_faults(w_q.stat);
        retire_cnt_d = retire_cnt_q + XLEN'(we_c && !W_stall_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_q          <= W_BUBBLE;
            halted_q     <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            w_q          <= w_d;
            halted_q     <= halted_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    rf_core u_rf_core (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_i     (we_c),
        .dst_e_i  (w_q.dst_e),
        .val_e_i  (w_q.val_e),
        .dst_m_i  (w_q.dst_m),
        .val_m_i  (w_q.val_m),
        .src_a_i  (d_srcA_i),
        .src_b_i  (d_srcB_i),
        .rval_a_o (d_rvalA_o),
        .rval_b_o (d_rvalB_o)
    );

    assign W_stat_o     = w_q.stat;
    assign W_icode_o    = w_q.icode;
    assign W_valE_o     = w_q.val_e;
    assign W_valM_o     = w_q.val_m;
    assign W_dstE_o     = w_q.dst_e;
    assign W_dstM_o     = w_q.dst_m;
    assign halted_o     = halted_q;
    assign retire_cnt_o = retire_cnt_q;

endmodule
